// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- control/fetch bundle between the control unit and the
// program-counter sequencer.
//
// master : control side (drives START/HALT/branch/call controls and the
//          program entry table, observes PC and status)
// slave  : the sequencer itself
//
// Signals:
//   START, HALT, Branch, Zero, BranchRel, Call, Ret   control strobes/levels
//   Offset        signed relative branch offset (OFFW)
//   AbsoluteAddr  absolute branch/call target (PCW)
//   ProgBase      program entry table, entry i at [i*PCW +: PCW]
//   PC, ProgIdx   fetch address and current program index
//   Running, Done, Err  status flags
interface pc_sequencer_if #(
    parameter int PCW   = 16,
    parameter int NPROG = 3,
    parameter int OFFW  = 8
);
    localparam int IW = (NPROG > 1) ? $clog2(NPROG) : 1;

    logic                  START;
    logic                  HALT;
    logic                  Branch;
    logic                  Zero;
    logic                  BranchRel;
    logic [OFFW-1:0]       Offset;
    logic [PCW-1:0]        AbsoluteAddr;
    logic                  Call;
    logic                  Ret;
    logic [NPROG*PCW-1:0]  ProgBase;
    logic [PCW-1:0]        PC;
    logic [IW-1:0]         ProgIdx;
    logic                  Running;
    logic                  Done;
    logic                  Err;

    modport master (
        output START, HALT, Branch, Zero, BranchRel, Offset, AbsoluteAddr,
               Call, Ret, ProgBase,
        input  PC, ProgIdx, Running, Done, Err
    );

    modport slave (
        input  START, HALT, Branch, Zero, BranchRel, Offset, AbsoluteAddr,
               Call, Ret, ProgBase,
        output PC, ProgIdx, Running, Done, Err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter for the Divvy core. Sequences NPROG programs
// from an entry table, takes zero-flag branches (absolute or PC-relative) and
// optionally maintains a hardware call/return stack.
//
// Ports:
//   CLK    clock, all state changes on the rising edge
//   RESET  asynchronous active-high reset
//   bus    pc_sequencer_if.slave (controls in, PC/ProgIdx/status out)
//
// Build option:
//   PC_SEQUENCER_STACK_EN  when defined, the call stack, Call/Ret handling and
//                          the Err fault paths are included. Otherwise Call and
//                          Ret are ignored and Err is constant 0.
module pc_sequencer #(
    parameter int PCW    = 16,
    parameter int NPROG  = 3,
    parameter int OFFW   = 8,
    parameter int SDEPTH = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    pc_sequencer_if.slave bus
);
    localparam int IW = (NPROG > 1) ? $clog2(NPROG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NPROG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HALTED,
        S_DONE
    } state_t;

    state_t                    state;
    logic [PCW-1:0]            pc;
    logic [IW-1:0]             idx;
    logic                      running;
    logic                      done;

    logic [NPROG-1:0][PCW-1:0] base_tbl;
    logic [PCW-1:0]            pc_inc;
    logic [PCW-1:0]            br_target;
    logic                      take_branch;
    logic                      run_cycle;

    // Stack-facing signals; constant in the stackless build.
    logic                      do_ret;
    logic                      do_call;
    logic                      stk_empty;
    logic                      stk_full;
    logic [PCW-1:0]            stk_top;

    assign base_tbl    = bus.ProgBase;
    assign pc_inc      = pc + PCW'(1);
    assign br_target   = bus.BranchRel
                       ? pc + {{(PCW-OFFW){bus.Offset[OFFW-1]}}, bus.Offset}
                       : bus.AbsoluteAddr;
    assign take_branch = bus.Branch && bus.Zero;
    // A RUN cycle not pre-empted by restart or halt; Ret/Call act only here.
    assign run_cycle   = (state == S_RUN) && !bus.START && !bus.HALT;

`ifdef PC_SEQUENCER_STACK_EN
    localparam int SPW = $clog2(SDEPTH) + 1;

    logic [PCW-1:0]            stk [SDEPTH];
    logic [SPW-1:0]            sp;          // number of live entries
    logic [SPW-2:0]            top_ptr;
    logic                      err;
    logic                      load_next;

    assign top_ptr   = sp[SPW-2:0] - (SPW-1)'(1);
    assign stk_top   = stk[top_ptr];
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == SPW'(SDEPTH));
    assign do_ret    = run_cycle && bus.Ret;
    assign do_call   = run_cycle && !bus.Ret && bus.Call;

    // Every edge that leaves the FSM in LOAD empties the stack and clears Err.
    assign load_next = bus.START &&
                       ((state == S_IDLE) || (state == S_LOAD) || (state == S_RUN) ||
                        ((state == S_HALTED) && (idx != LAST_IDX)));

    // Storage needs no reset: entries are only read below the stack pointer.
    always_ff @(posedge CLK) begin
        if (do_call && !stk_full)
            stk[sp[SPW-2:0]] <= pc_inc;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sp  <= '0;
            err <= 1'b0;
        end else if (load_next) begin
            sp  <= '0;
            err <= 1'b0;
        end else if (do_ret) begin
            if (stk_empty) err <= 1'b1;
            else           sp  <= sp - SPW'(1);
        end else if (do_call) begin
            if (stk_full)  err <= 1'b1;
            else           sp  <= sp + SPW'(1);
        end
    end

    assign bus.Err = err;
`else
    logic unused_ok;

    assign do_ret    = 1'b0;
    assign do_call   = 1'b0;
    assign stk_empty = 1'b0;
    assign stk_full  = 1'b0;
    assign stk_top   = '0;
    assign unused_ok = &{1'b0, bus.Call, bus.Ret, SDEPTH[0]};
    assign bus.Err   = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            pc      <= '0;
            idx     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.START) begin
                        state <= S_LOAD;
                        idx   <= '0;
                        pc    <= base_tbl[0];
                    end
                end
                S_LOAD: begin
                    if (bus.START) begin
                        pc <= base_tbl[idx];
                    end else begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.START) begin
                        state   <= S_LOAD;
                        running <= 1'b0;
                        pc      <= base_tbl[idx];
                    end else if (bus.HALT) begin
                        state   <= S_HALTED;
                        running <= 1'b0;
                    end else if (do_ret) begin
                        if (stk_empty) begin
                            state   <= S_HALTED;
                            running <= 1'b0;
                        end else begin
                            pc <= stk_top;
                        end
                    end else if (do_call) begin
                        if (stk_full) begin
                            state   <= S_HALTED;
                            running <= 1'b0;
                        end else begin
                            pc <= bus.AbsoluteAddr;
                        end
                    end else if (take_branch) begin
                        pc <= br_target;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                S_HALTED: begin
                    if (bus.START) begin
                        if (idx == LAST_IDX) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOAD;
                            idx   <= idx + IW'(1);
                            pc    <= base_tbl[idx + IW'(1)];
                        end
                    end
                end
                S_DONE: ;
                default: begin
                    state   <= S_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC      = pc;
    assign bus.ProgIdx = idx;
    assign bus.Running = running;
    assign bus.Done    = done;
endmodule
